// File: rtl/lane_game_pkg.sv
// lane_game_pkg: shared FSM/judgment types and the combo multiplier used when COMBO_MULT_EN is defined
package lane_game_pkg;
    typedef enum logic [1:0] {IDLE, WINDOW, WAIT} state_t;
    typedef enum logic [1:0] {J_NONE, J_HIT, J_MISS} judge_t;
    localparam int unsigned MULT_T1 = 10;
    localparam int unsigned MULT_T2 = 20;
    localparam int unsigned MULT_T3 = 30;
    function automatic logic [2:0] mult_f(input int unsigned c);
        return c >= MULT_T3 ? 3'd4 : c >= MULT_T2 ? 3'd3 : c >= MULT_T1 ? 3'd2 : 3'd1;
    endfunction
endpackage

// File: rtl/score_bcd_conv.sv
// score_bcd_conv: sequential shift-add-3 binary to BCD converter, busy for SCORE_W+1 cycles per conversion
module score_bcd_conv #(
    parameter int SCORE_W = 14,
    parameter int DIGITS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);
    localparam int CW = $clog2(SCORE_W + 1);
    logic [SCORE_W-1:0]  sh;
    logic [4*DIGITS-1:0] acc, adj;
    logic [CW-1:0]       cnt;
    // add 3 to every digit that will overflow past 9 on the next shift
    always_comb begin
        adj = acc;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = acc[4*i+:4] >= 4'd5 ? acc[4*i+:4] + 4'd3 : acc[4*i+:4];
    end
    // latch on start, shift SCORE_W times, then publish the result in one finishing cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
            acc  <= '0;
            sh   <= '0;
            cnt  <= '0;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy <= 1'b1;
                    sh   <= bin;
                    acc  <= '0;
                    cnt  <= CW'(SCORE_W);
                end
            end else if (cnt != '0) begin
                acc <= {adj[4*DIGITS-2:0], sh[SCORE_W-1]};
                sh  <= sh << 1;
                cnt <= cnt - 1'b1;
            end else begin
                busy <= 1'b0;
                done <= 1'b1;
                bcd  <= acc;
            end
        end
    end
endmodule

// File: rtl/lane_score_engine.sv
// lane_score_engine: timed note judging, combo and saturating score with BCD readout; COMBO_MULT_EN enables the combo multiplier
import lane_game_pkg::*;

module lane_score_engine #(
    parameter int NUM_LANES      = 5,
    parameter int WINDOW_CYCLES  = 25000,
    parameter int SCORE_W        = 14,
    parameter int MAX_SCORE      = 9999,
    parameter int POINTS_PER_HIT = 10,
    parameter int COMBO_W        = 8,
    parameter int DIGITS         = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play_en,
    input  logic                  step_valid,
    input  logic [NUM_LANES-1:0]  note_mask,
    input  logic [NUM_LANES-1:0]  btn_level,
    output logic                  hit_pulse,
    output logic                  miss_pulse,
    output logic                  window_open,
    output logic [SCORE_W-1:0]    score,
    output logic [COMBO_W-1:0]    combo,
    output logic [4*DIGITS-1:0]   score_bcd,
    output logic                  bcd_valid
);
    localparam int TW = $clog2(WINDOW_CYCLES);
    state_t               state, state_nx;
    judge_t               judge;
    logic [TW-1:0]        timer;
    logic [NUM_LANES-1:0] note_reg, btn_prev, edge_q, pressed_acc, acc;
    logic                 open_w, hit_c, miss_c, pending, conv_busy, conv_done, conv_start;
    logic [2:0]           mult;
    logic [31:0]          sum;
    logic [SCORE_W-1:0]   score_nx;
    logic [COMBO_W-1:0]   combo_nx;
`ifdef COMBO_MULT_EN
    assign mult = mult_f(32'(combo));
`else
    assign mult = 3'd1;
`endif
    // judgment, next state and next score/combo; a completing press beats a concurrent step or timeout
    always_comb begin
        acc        = pressed_acc | edge_q;
        open_w     = step_valid && note_mask != '0;
        hit_c      = state == WINDOW && acc == note_reg;
        miss_c     = state == WINDOW && (|(acc & ~note_reg) || timer == '0 || step_valid);
        judge      = !play_en ? J_NONE : hit_c ? J_HIT : miss_c ? J_MISS : J_NONE;
        state_nx   = !play_en ? IDLE : step_valid ? (open_w ? WINDOW : WAIT) : judge != J_NONE ? WAIT : state;
        sum        = 32'(score) + 32'(POINTS_PER_HIT) * 32'(mult);
        score_nx   = judge == J_HIT ? (sum > 32'(MAX_SCORE) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0]) : score;
        combo_nx   = judge == J_MISS ? '0 : (judge == J_HIT && combo != '1) ? combo + 1'b1 : combo;
        conv_start = !conv_busy && (score_nx != score || (pending && conv_done));
    end
    // registered press detection, window timing, pulses, score/combo and BCD restart bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            note_reg    <= '0;
            btn_prev    <= '0;
            edge_q      <= '0;
            pressed_acc <= '0;
            hit_pulse   <= 1'b0;
            miss_pulse  <= 1'b0;
            window_open <= 1'b0;
            score       <= '0;
            combo       <= '0;
            pending     <= 1'b0;
        end else begin
            state       <= state_nx;
            btn_prev    <= btn_level;
            edge_q      <= btn_level & ~btn_prev;
            hit_pulse   <= judge == J_HIT;
            miss_pulse  <= judge == J_MISS;
            window_open <= state_nx == WINDOW;
            score       <= score_nx;
            combo       <= combo_nx;
            pending     <= conv_busy && (pending || score_nx != score);
            pressed_acc <= play_en && open_w ? '0 : acc;
            if (play_en && open_w) begin
                timer    <= TW'(WINDOW_CYCLES - 1);
                note_reg <= note_mask;
            end else if (timer != '0) begin
                timer <= timer - 1'b1;
            end
        end
    end
    assign bcd_valid = !conv_busy && !pending;
    score_bcd_conv #(.SCORE_W(SCORE_W), .DIGITS(DIGITS)) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (score_nx),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (score_bcd)
    );
endmodule
